// File: rtl/hazard_stall_ctrl.sv
// Load-use and multdiv hazard stall controller for the F/D -> D/X -> X/M pipeline.
// Drives PC/latch hold and bubble controls and keeps a saturating stall-cycle count.
module hazard_stall_ctrl #(
  parameter int LOAD_LAT   = 1,
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      fd_insn,
  input  logic [31:0]      dx_insn,
  input  logic             dx_valid,
  input  logic             md_ready,
  input  logic             flush,
  input  logic             clr_stats,
  output logic             stall_pc,
  output logic             stall_fd,
  output logic             bubble_dx,
  output logic             hold_dx,
  output logic             bubble_xm,
  output logic             md_start,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {IDLE, LOAD_STALL, MD_BUSY} state_e;

  localparam logic [7:0] LD_INIT = 8'(LOAD_LAT - 1);
  localparam logic [7:0] MD_INIT = 8'(MD_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]  cycles_q;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt, dx_op, dx_rd, dx_alu;
  logic [4:0] src_a, src_b;
  logic       use_a, use_b, load_hit, md_hit;
  logic       pc_c, fd_c, bdx_c, hdx_c, bxm_c, start_c, tmo_c;
  logic       unused_bits;

  assign fd_op  = fd_insn[31:27];
  assign fd_rd  = fd_insn[26:22];
  assign fd_rs  = fd_insn[21:17];
  assign fd_rt  = fd_insn[16:12];
  assign dx_op  = dx_insn[31:27];
  assign dx_rd  = dx_insn[26:22];
  assign dx_alu = dx_insn[6:2];
  assign unused_bits = ^{fd_insn[11:0], dx_insn[21:7], dx_insn[1:0]};

  // Source-register usage of the F/D instruction, by opcode class.
  always_comb begin
    use_a = 1'b0;
    use_b = 1'b0;
    src_a = fd_rs;
    src_b = fd_rt;
    case (fd_op)
      5'b00000:                   begin use_a = 1'b1; use_b = 1'b1; end
      5'b00101, 5'b01000:         begin use_a = 1'b1; end
      5'b00111, 5'b00010, 5'b00110: begin
        use_a = 1'b1; use_b = 1'b1; src_a = fd_rd; src_b = fd_rs;
      end
      5'b00100:                   begin use_a = 1'b1; src_a = fd_rd; end
      default: ;
    endcase
  end

  assign load_hit = dx_valid && (dx_op == 5'b01000) && (dx_rd != 5'd0) &&
                    ((use_a && (dx_rd == src_a)) || (use_b && (dx_rd == src_b)));
  assign md_hit   = dx_valid && (dx_op == 5'b00000) &&
                    ((dx_alu == 5'b00110) || (dx_alu == 5'b00111));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_c    = 1'b0;
    fd_c    = 1'b0;
    bdx_c   = 1'b0;
    hdx_c   = 1'b0;
    bxm_c   = 1'b0;
    start_c = 1'b0;
    tmo_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush) begin
          if (md_hit) begin
            start_c = 1'b1; pc_c = 1'b1; fd_c = 1'b1; hdx_c = 1'b1; bxm_c = 1'b1;
            cnt_d   = MD_INIT;
            state_d = MD_BUSY;
          end else if (load_hit) begin
            pc_c = 1'b1; fd_c = 1'b1; bdx_c = 1'b1;
            if (LOAD_LAT > 1) begin
              cnt_d   = LD_INIT;
              state_d = LOAD_STALL;
            end
          end
        end
      end
      LOAD_STALL: begin
        if (flush) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          pc_c  = 1'b1; fd_c = 1'b1; bdx_c = 1'b1;
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = IDLE;
        end
      end
      MD_BUSY: begin
        // flush is deliberately ignored: the multdiv op owns the D/X slot.
        if (md_ready) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else if (cnt_q == 8'd0) begin
          tmo_c   = 1'b1;
          state_d = IDLE;
        end else begin
          pc_c  = 1'b1; fd_c = 1'b1; hdx_c = 1'b1; bxm_c = 1'b1;
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                           cycles_q <= '0;
    else if (clr_stats)                   cycles_q <= '0;
    else if (pc_c && (cycles_q != '1))    cycles_q <= cycles_q + 1'b1;
  end

  // Gate with reset so a live hazard on the inputs cannot leak out during reset.
  assign stall_pc     = reset & pc_c;
  assign stall_fd     = reset & fd_c;
  assign bubble_dx    = reset & bdx_c;
  assign hold_dx      = reset & hdx_c;
  assign bubble_xm    = reset & bxm_c;
  assign md_start     = reset & start_c;
  assign md_timeout   = reset & tmo_c;
  assign stall_cycles = cycles_q;

endmodule
